// File: rtl/mips_div_pkg.sv
// Shared definitions for the MIPS DIV/DIVU sequential divider.
// Holds the FSM state encoding and the default operand width.
package mips_div_pkg;

    localparam int DEF_WIDTH = 32;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] FIXUP = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

endpackage

// File: rtl/mips_divider_div_step.sv
// One restoring-division iteration: conditional subtract of the divisor.
// Purely combinational, zero latency, no flow control.
module div_step
    import mips_div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH-1:0] diff;

    // When the subtract succeeds the difference is below the divisor, so the
    // low WIDTH bits of the partial remainder are enough to form it.
    assign q_bit   = (rem_in >= {1'b0, divisor});
    assign diff    = rem_in[WIDTH-1:0] - divisor;
    assign rem_out = q_bit ? diff : rem_in[WIDTH-1:0];

endmodule

// File: rtl/mips_divider.sv
// Sequential MIPS DIV/DIVU unit: restoring division, one quotient bit per cycle.
// Latency WIDTH+2 cycles from accepted start to the done pulse.
// No backpressure: start is only honoured in IDLE, otherwise dropped.
module mips_divider
    import mips_div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [1:0]       state;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] dvs_reg;
    logic             q_neg;
    logic             r_neg;
    logic             dbz_lat;

    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic             dvd_neg;
    logic             dvs_neg;

    assign dvd_neg = is_signed & dividend[WIDTH-1];
    assign dvs_neg = is_signed & divisor[WIDTH-1];

    // quo_reg starts out holding the dividend magnitude; its MSB feeds the
    // partial remainder while quotient bits fill in from the bottom.
    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  ({rem_reg, quo_reg[WIDTH-1]}),
        .divisor (dvs_reg),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    assign busy = (state == RUN) || (state == FIXUP);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            count       <= '0;
            rem_reg     <= '0;
            quo_reg     <= '0;
            dvs_reg     <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            dbz_lat     <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        rem_reg <= '0;
                        quo_reg <= dvd_neg ? -dividend : dividend;
                        dvs_reg <= dvs_neg ? -divisor : divisor;
                        q_neg   <= dvd_neg ^ dvs_neg;
                        r_neg   <= dvd_neg;
                        dbz_lat <= (divisor == '0);
                        count   <= CNT_W'(WIDTH - 1);
                        state   <= RUN;
                    end
                end
                RUN: begin
                    rem_reg <= step_rem;
                    quo_reg <= {quo_reg[WIDTH-2:0], step_q};
                    count   <= count - 1'b1;
                    if (count == '0) begin
                        state <= FIXUP;
                    end
                end
                FIXUP: begin
                    // A zero divisor yields all-ones magnitude; force it so the
                    // sign fixup cannot turn it into +1. The remainder magnitude
                    // negated back is the original dividend in every case.
                    if (dbz_lat) begin
                        quotient <= '1;
                    end else begin
                        quotient <= q_neg ? -quo_reg : quo_reg;
                    end
                    remainder   <= r_neg ? -rem_reg : rem_reg;
                    div_by_zero <= dbz_lat;
                    state       <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mips_divider.md
MIPS_DIVIDER -- requirements
Module: mips_divider

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits.
REQ-002 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  request to begin a division; sampled only in IDLE.
REQ-005 Port: is_signed  input  1  1 = DIV (two's complement), 0 = DIVU; latched with start.
REQ-006 Port: dividend  input  WIDTH  numerator; latched with start.
REQ-007 Port: divisor  input  WIDTH  denominator; latched with start.
REQ-008 Port: busy  output  1  high while a division is in progress.
REQ-009 Port: done  output  1  single-cycle pulse when results become valid.
REQ-010 Port: quotient  output  WIDTH  LO result, held until next accepted start.
REQ-011 Port: remainder  output  WIDTH  HI result, held until next accepted start.
REQ-012 Port: div_by_zero  output  1  set with done when latched divisor was 0; held with results.

Function
REQ-013 FSM states SHALL be IDLE, RUN, FIXUP, DONE.
REQ-014 IDLE: start=1 SHALL latch operands and is_signed, load iteration counter = WIDTH-1, go to RUN; busy high from next cycle.
REQ-015 Signed mode SHALL convert operands to magnitudes on latch and record quotient sign (XOR of operand signs) and remainder sign (dividend sign).
REQ-016 RUN: one restoring-division step per cycle (shift partial remainder left, bring in next dividend bit MSB first, conditional subtract of divisor magnitude, shift quotient bit in); exactly WIDTH cycles, then FIXUP.
REQ-017 FIXUP: negate quotient/remainder per recorded signs (signed only), drive outputs, go to DONE.
REQ-018 DONE: done=1 for exactly one cycle, busy=0, then IDLE.
REQ-019 Latency: start accepted in cycle N -> done high in cycle N+WIDTH+2; busy high cycles N+1 .. N+WIDTH+1.
REQ-020 start while busy or in DONE SHALL be ignored, no effect on operands or results.
REQ-021 start in IDLE in the same cycle that done drops SHALL be accepted (back-to-back operation).
REQ-022 Signed results: quotient truncates toward zero; remainder has sign of dividend; dividend = quotient*divisor + remainder.
REQ-023 Divisor 0 (either mode): quotient = all ones, remainder = original dividend unmodified, div_by_zero=1, same latency.
REQ-024 Signed overflow (most-negative / -1): quotient = most-negative value, remainder = 0, div_by_zero=0.
REQ-025 quotient, remainder, div_by_zero SHALL change only in FIXUP; outputs stay stable at all other times.

Reset
REQ-026 reset=1 at any clock edge SHALL force IDLE and clear busy, done, quotient, remainder, div_by_zero and all internal registers to 0.
REQ-027 Reset mid-RUN SHALL abort the division; no done pulse for the aborted operation.
REQ-028 reset takes priority over start in the same cycle.

Structure
REQ-029 Shared package mips_div_pkg SHALL hold the state enum (IDLE, RUN, FIXUP, DONE) and the default WIDTH constant.
REQ-030 One combinational sub-module div_step SHALL implement a single conditional-subtract iteration (inputs partial remainder, divisor; outputs next remainder, quotient bit); mips_divider instantiates it once.

Verification
REQ-031 Unsigned 100 / 7, start in cycle 0 -> done in cycle 34, quotient=14, remainder=2, div_by_zero=0.
REQ-032 Signed 0xFFFFFFF9 (-7) / 2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1).
REQ-033 Signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0, div_by_zero=0.
REQ-034 Unsigned 5 / 0 -> quotient=0xFFFFFFFF, remainder=5, div_by_zero=1, done in cycle 34.
REQ-035 Start 0xFFFFFFFF / 1 unsigned; pulse start with other operands in cycle 10 -> ignored, result quotient=0xFFFFFFFF, remainder=0; second start in cycle 35 accepted.
REQ-036 Start 100 / 7, reset in cycle 10 -> from cycle 11 busy=0, all outputs 0, no done pulse through cycle 40.
